// File: rtl/instr_dispatch_ctrl_if.sv
// Bus/handshake bundle between the instruction dispatch controller and its
// memory path and execution units.
// master: the dispatch controller. slave: memory path, units, run source.
interface instr_dispatch_ctrl_if;
  logic        run;
  logic [15:0] bus_in;
  logic        MFC;
  logic        ldst_done;
  logic        alu_done;
  logic        PC_out;
  logic        PC_inc;
  logic        MAR_EN;
  logic        mem_EN;
  logic        mem_RW;
  logic        MDR_EN_read;
  logic        MDR_out;
  logic [15:0] instr;
  logic        ldst_go;
  logic        alu_go;
  logic        busy;
  logic        halted;
  logic        err;

  modport master (
    input  run, bus_in, MFC, ldst_done, alu_done,
    output PC_out, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out,
    output instr, ldst_go, alu_go, busy, halted, err
  );

  modport slave (
    output run, bus_in, MFC, ldst_done, alu_done,
    input  PC_out, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out,
    input  instr, ldst_go, alu_go, busy, halted, err
  );
endinterface

// File: rtl/instr_dispatch_ctrl.sv
// Instruction sequencer: fetches a 16-bit word over the MAR/MDR path, latches
// it in IR, decodes opcode [15:12] and dispatches to the load/store or ALU
// unit, waiting for that unit's done. Waits on MFC/done are bounded by
// TIMEOUT_CYC cycles; expiry parks the sequencer in ERROR until reset.
// Optional build macro SINGLE_STEP_EN adds a 'step' input; each new fetch then
// needs a rising edge on step (with run=1).
module instr_dispatch_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [3:0]  HALT_OP     = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  instr_dispatch_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_WAIT,
    S_FETCH_LATCH,
    S_IR_LOAD,
    S_DECODE,
    S_EXEC_LDST,
    S_EXEC_ALU,
    S_BOUNDARY,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] ir;
  logic [7:0]  cnt;
  logic        tmo;
  logic        go_ok;
  logic        wait_cur;
  logic        wait_nxt;

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  // Registered rising-edge detect of the step request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q    <= 1'b0;
      step_rise <= 1'b0;
    end else begin
      step_q    <= step;
      step_rise <= step & ~step_q;
    end
  end

  assign go_ok = step_rise;
`else
  assign go_ok = 1'b1;
`endif

  // Timeout fires on the last permitted cycle of a wait; the awaited event
  // is tested first in the next-state logic so it wins a tie.
  assign tmo      = (cnt == TMO_LAST);
  assign wait_cur = (state == S_FETCH_WAIT) || (state == S_EXEC_LDST) || (state == S_EXEC_ALU);
  assign wait_nxt = (nxt == S_FETCH_WAIT) || (nxt == S_EXEC_LDST) || (nxt == S_EXEC_ALU);

  // Next-state selection
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:        if (bus.run && go_ok) nxt = S_FETCH_ADDR;
      S_FETCH_ADDR:  nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (bus.MFC)  nxt = S_FETCH_LATCH;
        else if (tmo) nxt = S_ERROR;
      end
      S_FETCH_LATCH: nxt = S_IR_LOAD;
      S_IR_LOAD:     nxt = S_DECODE;
      S_DECODE: begin
        if (ir[15:12] == 4'd0)                              nxt = S_BOUNDARY;
        else if (ir[15:12] == HALT_OP)                      nxt = S_HALT;
        else if ((ir[15:12] == 4'd3) || (ir[15:12] == 4'd4)) nxt = S_EXEC_LDST;
        else                                                nxt = S_EXEC_ALU;
      end
      S_EXEC_LDST: begin
        if (bus.ldst_done) nxt = S_BOUNDARY;
        else if (tmo)      nxt = S_ERROR;
      end
      S_EXEC_ALU: begin
        if (bus.alu_done)  nxt = S_BOUNDARY;
        else if (tmo)      nxt = S_ERROR;
      end
      S_BOUNDARY: begin
        if (!bus.run)   nxt = S_IDLE;
        else if (go_ok) nxt = S_FETCH_ADDR;
      end
      S_HALT:        nxt = S_HALT;
      S_ERROR:       nxt = S_ERROR;
      default:       nxt = S_IDLE;
    endcase
  end

  // State, IR, wait counter and outputs registered from the next state, so
  // each output is a pure function of the state it is presented with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      ir              <= '0;
      cnt             <= '0;
      bus.PC_out      <= 1'b0;
      bus.PC_inc      <= 1'b0;
      bus.MAR_EN      <= 1'b0;
      bus.mem_EN      <= 1'b0;
      bus.mem_RW      <= 1'b0;
      bus.MDR_EN_read <= 1'b0;
      bus.MDR_out     <= 1'b0;
      bus.instr       <= '0;
      bus.ldst_go     <= 1'b0;
      bus.alu_go      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IR_LOAD) ir <= bus.bus_in;

      if (wait_nxt && (nxt != state)) cnt <= '0;
      else if (wait_cur)              cnt <= cnt + 8'd1;
      else                            cnt <= '0;

      bus.PC_out      <= (nxt == S_FETCH_ADDR);
      bus.PC_inc      <= (nxt == S_FETCH_ADDR);
      bus.MAR_EN      <= (nxt == S_FETCH_ADDR);
      bus.mem_EN      <= (nxt == S_FETCH_WAIT) || (nxt == S_FETCH_LATCH);
      bus.mem_RW      <= (nxt == S_FETCH_WAIT) || (nxt == S_FETCH_LATCH);
      bus.MDR_EN_read <= (nxt == S_FETCH_LATCH);
      bus.MDR_out     <= (nxt == S_IR_LOAD);
      bus.instr       <= ((nxt == S_EXEC_LDST) || (nxt == S_EXEC_ALU)) ? ir : '0;
      bus.ldst_go     <= (nxt == S_EXEC_LDST);
      bus.alu_go      <= (nxt == S_EXEC_ALU);
      bus.busy        <= !((nxt == S_IDLE) || (nxt == S_HALT) || (nxt == S_ERROR));
      bus.halted      <= (nxt == S_HALT);
      bus.err         <= (nxt == S_ERROR);
    end
  end

endmodule
